des_decrypt_key_scheduler: RTL and testbench

Sequential DES round-key scheduler for the decryption direction of the DES engine. It accepts the 56-bit parity-dropped key (PC-1 output), rotates the C/D halves right, and emits the 16 round keys in reverse order (K16 first, K1 last), one per accepted handshake. It sits between the key-load logic and the decrypt datapath's round function, and consumes the same PC-1 key format as the encrypt-side key generator.

---
 rtl/des_decrypt_key_scheduler.sv | 117 +++++++++++
 tb/tb_des_decrypt_key_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_key_scheduler.sv
// des_decrypt_key_scheduler
// Produces the DES round keys K16..K1 for the decrypt datapath, one per
// valid/ready handshake. The PC-1 halves C and D are rotated right so the
// schedule walks the encrypt key sequence backwards. A start on the final
// handshake reloads immediately, so schedules run back to back with no gap.
module des_decrypt_key_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_din,
  input  logic [0:55] key_din,
  input  logic        key_ready_din,
  output logic        busy_dout,
  output logic        key_valid_dout,
  output logic [0:47] round_key_dout,
  output logic [3:0]  round_index_dout,
  output logic        last_dout
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [0:27] c_q, c_d;
  logic [0:27] d_q, d_d;
  logic [3:0]  round_q, round_d;

  logic        handshake;
  logic        final_round;
  logic        single_shift;
  logic [0:55] cd;

  // Handshake qualification and the rotate amount for the step leaving round_q
  always_comb begin
    handshake    = (state_q == RUN) && key_ready_din;
    final_round  = (round_q == 4'd15);
    single_shift = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);
  end

  // State register: FSM, key halves and round counter, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  // Next-state logic: load on start, rotate right on each handshake
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    case (state_q)
      IDLE: begin
        if (start_din) begin
          state_d = RUN;
          c_d     = key_din[0:27];
          d_d     = key_din[28:55];
          round_d = 4'd0;
        end
      end
      RUN: begin
        if (handshake) begin
          if (final_round) begin
            if (start_din) begin
              state_d = RUN;
              c_d     = key_din[0:27];
              d_d     = key_din[28:55];
              round_d = 4'd0;
            end else begin
              state_d = IDLE;
              round_d = 4'd0;
            end
          end else begin
            if (single_shift) begin
              c_d = {c_q[27], c_q[0:26]};
              d_d = {d_q[27], d_q[0:26]};
            end else begin
              c_d = {c_q[26:27], c_q[0:25]};
              d_d = {d_q[26:27], d_q[0:25]};
            end
            round_d = round_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: status from registered state, round key via PC-2 of {C,D}
  always_comb begin
    busy_dout        = (state_q == RUN);
    key_valid_dout   = (state_q == RUN);
    round_index_dout = round_q;
    last_dout        = (state_q == RUN) && final_round;
    cd               = {c_q, d_q};
    round_key_dout   = {
      cd[13], cd[16], cd[10], cd[23], cd[0],  cd[4],
      cd[2],  cd[27], cd[14], cd[5],  cd[20], cd[9],
      cd[22], cd[18], cd[11], cd[3],  cd[25], cd[7],
      cd[15], cd[6],  cd[26], cd[19], cd[12], cd[1],
      cd[40], cd[51], cd[30], cd[36], cd[46], cd[54],
      cd[29], cd[39], cd[50], cd[44], cd[32], cd[47],
      cd[43], cd[48], cd[38], cd[55], cd[33], cd[52],
      cd[45], cd[41], cd[49], cd[35], cd[28], cd[31]
    };
  end

endmodule

// File: tb/tb_des_decrypt_key_scheduler.sv
// tb_des_decrypt_key_scheduler
// Drives directed schedules into the decrypt key scheduler. An encrypt-side
// key generator model builds K1..K16 and queues them in reverse order; every
// cycle the queue head is compared against the DUT outputs.
module tb_des_decrypt_key_scheduler;

  localparam logic [0:55] STD_KEY = 56'hF0CCAAF556678F;

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [3:0]  idx;
    logic [0:47] key;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_din;
  logic [0:55] key_din;
  logic        key_ready_din;
  logic        busy_dout;
  logic        key_valid_dout;
  logic [0:47] round_key_dout;
  logic [3:0]  round_index_dout;
  logic        last_dout;

  sb_item_t    sb_q [$];
  logic [0:47] obs_key [16];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_cyc = 0;
  logic [0:55] key_a;

  des_decrypt_key_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .start_din        (start_din),
    .key_din          (key_din),
    .key_ready_din    (key_ready_din),
    .busy_dout        (busy_dout),
    .key_valid_dout   (key_valid_dout),
    .round_key_dout   (round_key_dout),
    .round_index_dout (round_index_dout),
    .last_dout        (last_dout)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Encrypt-direction generator: left rotations, K1..K16, queued K16 first
  task automatic push_schedule(input logic [0:55] key);
    logic [0:27] c;
    logic [0:27] d;
    logic [0:55] cd;
    logic [0:47] k;
    logic [5:0]  pos;
    logic [0:47] enc [16];
    sb_item_t    item;
    c = key[0:27];
    d = key[28:55];
    for (int i = 0; i < 16; i++) begin
      for (int s = 0; s < ENC_SHIFT[i]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      k = '0;
      for (int b = 0; b < 48; b++) begin
        pos = 6'(PC2_TAB[b] - 1);
        k = {k[1:47], cd[pos]};
      end
      enc[i] = k;
    end
    for (int r = 0; r < 16; r++) begin
      item.idx = 4'(r);
      item.key = enc[15 - r];
      sb_q.push_back(item);
    end
  endtask

  // One cycle: check outputs against the queue head, then drive inputs
  task automatic apply_stimulus(input logic rdy, input logic st, input logic [0:55] k);
    sb_item_t exp_item;
    @(negedge clk);
    cyc++;
    check_output("busy", 64'(busy_dout), 64'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      exp_item = sb_q[0];
      check_output("valid", 64'(key_valid_dout), 64'd1);
      check_output("index", 64'(round_index_dout), 64'(exp_item.idx));
      check_output("key", 64'(round_key_dout), 64'(exp_item.key));
      check_output("last", 64'(last_dout), 64'(exp_item.idx == 4'd15));
      if (rdy) begin
        obs_key[exp_item.idx] = round_key_dout;
        if (exp_item.idx == 4'd15) last_cyc = cyc;
        void'(sb_q.pop_front());
      end
    end else begin
      check_output("valid_idle", 64'(key_valid_dout), 64'd0);
      check_output("last_idle", 64'(last_dout), 64'd0);
    end
    if (st && (sb_q.size() == 0)) begin
      push_schedule(k);
      start_cyc = cyc;
    end
    key_ready_din = rdy;
    start_din     = st;
    key_din       = k;
  endtask

  task automatic drain(input bit random_ready, input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0) && (n < budget)) begin
      apply_stimulus(random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, '0);
      n++;
    end
    check_output("drain_timeout", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_busy"}, 64'(busy_dout), 64'd0);
    check_output({tag, "_valid"}, 64'(key_valid_dout), 64'd0);
    check_output({tag, "_index"}, 64'(round_index_dout), 64'd0);
    check_output({tag, "_last"}, 64'(last_dout), 64'd0);
    check_output({tag, "_key"}, 64'(round_key_dout), 64'd0);
  endtask

  // Directed sequence
  initial begin
    reset         = 1'b1;
    start_din     = 1'b0;
    key_din       = '0;
    key_ready_din = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    $display("[TB] standard key, ready high");
    apply_stimulus(1'b0, 1'b1, STD_KEY);
    drain(1'b0, 40);
    apply_stimulus(1'b1, 1'b0, '0);
    check_output("std_k16", 64'(obs_key[0]), 64'h CB3D8B0E17F5);
    check_output("std_k15", 64'(obs_key[1]), 64'h BF918D3D3F0A);
    check_output("std_k2", 64'(obs_key[14]), 64'h 79AED9DBC9E5);
    check_output("std_k1", 64'(obs_key[15]), 64'h 1B02EFFC7072);
    check_output("std_last_latency", 64'(last_cyc - start_cyc), 64'd16);

    $display("[TB] standard key, random backpressure");
    apply_stimulus(1'b0, 1'b1, STD_KEY);
    drain(1'b1, 400);
    apply_stimulus(1'b0, 1'b0, '0);
    check_output("bp_k16", 64'(obs_key[0]), 64'h CB3D8B0E17F5);
    check_output("bp_k1", 64'(obs_key[15]), 64'h 1B02EFFC7072);

    $display("[TB] all-zero and all-ones keys");
    apply_stimulus(1'b0, 1'b1, 56'h0);
    drain(1'b0, 40);
    check_output("zero_first", 64'(obs_key[0]), 64'h0);
    check_output("zero_last", 64'(obs_key[15]), 64'h0);
    apply_stimulus(1'b0, 1'b1, 56'hFFFFFFFFFFFFFF);
    drain(1'b0, 40);
    check_output("ones_first", 64'(obs_key[0]), 64'hFFFFFFFFFFFF);
    check_output("ones_last", 64'(obs_key[15]), 64'hFFFFFFFFFFFF);

    $display("[TB] start ignored while busy");
    key_a = 56'({$urandom, $urandom});
    apply_stimulus(1'b0, 1'b1, key_a);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, STD_KEY);
    drain(1'b0, 40);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] back-to-back restart");
    key_a = 56'({$urandom, $urandom});
    apply_stimulus(1'b0, 1'b1, key_a);
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, STD_KEY);
    apply_stimulus(1'b1, 1'b0, '0);
    check_output("b2b_k16", 64'(obs_key[0]), 64'h CB3D8B0E17F5);
    drain(1'b0, 40);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] reset mid-schedule");
    apply_stimulus(1'b0, 1'b1, STD_KEY);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, '0);
    @(negedge clk);
    check_output("pre_reset_index", 64'(round_index_dout), 64'd7);
    reset         = 1'b1;
    key_ready_din = 1'b0;
    start_din     = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b1, STD_KEY);
    drain(1'b0, 40);
    check_output("post_reset_k16", 64'(obs_key[0]), 64'h CB3D8B0E17F5);
    check_output("post_reset_k1", 64'(obs_key[15]), 64'h 1B02EFFC7072);
    apply_stimulus(1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
